// File: rtl/lc3_mem_pkg.sv
// Shared constants and FSM state encoding for the LC-3 main-memory initiator.
package lc3_mem_pkg;

  localparam int LC3_WORD_W    = 16;
  localparam int LC3_MEM_DEPTH = 28800;
  localparam int LC3_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2,
    RESP     = 2'd3
  } lc3_mem_state_t;

endpackage

// File: rtl/lc3_mem_initiator_if.sv
// Memory-side bus of the LC-3 initiator: request phase (MEM_EN/RW/MAR/MDR)
// and the memory's ready flag plus combinational read bus.
interface lc3_mem_initiator_if
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = LC3_WORD_W,
  parameter int DATA_W = LC3_WORD_W
);

  logic              MEM_EN;
  logic              RW;
  logic [ADDR_W-1:0] MAR_OUT;
  logic [DATA_W-1:0] MDR_OUT;
  logic [DATA_W-1:0] MEM_OUT;
  logic              R;

  modport master (
    output MEM_EN, RW, MAR_OUT, MDR_OUT,
    input  MEM_OUT, R
  );

  modport slave (
    input  MEM_EN, RW, MAR_OUT, MDR_OUT,
    output MEM_OUT, R
  );

endinterface

// File: rtl/lc3_mem_timeout_ctr.sv
// Clearable, saturating wait-cycle counter; expired flags the last allowed
// cycle of a wait state.
module lc3_mem_timeout_ctr
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT = LC3_TIMEOUT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear wins over increment, saturates at LAST.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/lc3_mem_initiator.sv
// CPU-side initiator for the LC-3 memory four-phase handshake: one load/store
// at a time, range-checked, with per-wait-state timeout and a one-cycle response.
module lc3_mem_initiator
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W    = LC3_WORD_W,
  parameter int DATA_W    = LC3_WORD_W,
  parameter int MEM_DEPTH = LC3_MEM_DEPTH,
  parameter int TIMEOUT   = LC3_TIMEOUT
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  lc3_mem_initiator_if.master mem
);

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  lc3_mem_state_t    state_r;
  logic              mem_en_r;
  logic              rw_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mdr_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              rsp_valid_r;
  logic              req_ready_r;

  logic addr_ok_s;
  logic in_wait_s;
  logic wait_met_s;
  logic ctr_expired_s;
  logic ctr_clr_s;
  logic ctr_inc_s;

  assign addr_ok_s = ({1'b0, req_addr} < DEPTH_LIM);
  assign in_wait_s = (state_r == WAIT_ACK) || (state_r == WAIT_REL);

  // Wait condition of the current state: R high to acknowledge, low to release.
  always_comb begin
    wait_met_s = 1'b0;
    case (state_r)
      WAIT_ACK: wait_met_s = mem.R;
      WAIT_REL: wait_met_s = !mem.R;
      default:  wait_met_s = 1'b0;
    endcase
  end

  // Any exit from a wait state (met or expired) restarts the count for the next one.
  assign ctr_clr_s = !in_wait_s || wait_met_s || ctr_expired_s;
  assign ctr_inc_s = in_wait_s && !wait_met_s;

  lc3_mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .clr     (ctr_clr_s),
    .inc     (ctr_inc_s),
    .expired (ctr_expired_s)
  );

  // Handshake FSM with all outputs registered.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r     <= IDLE;
      mem_en_r    <= 1'b0;
      rw_r        <= 1'b0;
      mar_r       <= '0;
      mdr_r       <= '0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            mar_r       <= req_addr;
            mdr_r       <= req_wdata;
            rw_r        <= req_we;
            rdata_r     <= '0;
            req_ready_r <= 1'b0;
            if (addr_ok_s) begin
              err_r    <= 1'b0;
              mem_en_r <= 1'b1;
              state_r  <= WAIT_ACK;
            end else begin
              err_r       <= 1'b1;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end
          end
        end
        WAIT_ACK: begin
          if (mem.R) begin
            if (!rw_r) begin
              rdata_r <= mem.MEM_OUT;
            end
            mem_en_r <= 1'b0;
            state_r  <= WAIT_REL;
          end else if (ctr_expired_s) begin
            mem_en_r    <= 1'b0;
            err_r       <= 1'b1;
            rdata_r     <= '0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        WAIT_REL: begin
          if (!mem.R) begin
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (ctr_expired_s) begin
            err_r       <= 1'b1;
            rdata_r     <= '0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          mem_en_r    <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rdata_r;
  assign rsp_err     = err_r;
  assign mem.MEM_EN  = mem_en_r;
  assign mem.RW      = rw_r;
  assign mem.MAR_OUT = mar_r;
  assign mem.MDR_OUT = mdr_r;

endmodule

// File: tb/tb_lc3_mem_initiator.sv
// Directed self-checking bench for lc3_mem_initiator with a behavioural
// four-phase memory model (R follows MEM_EN one edge later).
module tb_lc3_mem_initiator;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic        mem_dead = 1'b0;
  logic [15:0] mem_arr [0:65535];

  always #5 i_Clk = ~i_Clk;

  lc3_mem_initiator_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  lc3_mem_initiator #(
    .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(28800), .TIMEOUT(15)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem       (bus)
  );

  // Memory model: write on the request edge, R tracks MEM_EN one edge late.
  always @(posedge i_Clk) begin
    bus.R <= bus.MEM_EN && !mem_dead;
    if (bus.MEM_EN && bus.RW && !bus.R && !mem_dead)
      mem_arr[bus.MAR_OUT] <= bus.MDR_OUT;
  end

  assign bus.MEM_OUT = mem_arr[bus.MAR_OUT];

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  // One request; lat counts edges after acceptance until rsp_valid is seen.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            output int lat, output int en_cyc, output logic [15:0] rdata,
                            output logic err, output logic one_pulse);
    int guard;
    lat = -1; en_cyc = 0; rdata = 16'hxxxx; err = 1'bx; one_pulse = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        tick();
        one_pulse = !rsp_valid && req_ready;
        break;
      end
      if (bus.MEM_EN) en_cyc++;
      tick();
    end
  endtask

  task automatic test_reset;
    i_Rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    tick(); tick();
    i_Rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0000", rsp_rdata); end
    checks++; if (bus.MEM_EN !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.MEM_EN); end
    checks++; if (bus.RW !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", bus.RW); end
    checks++; if (bus.MAR_OUT !== 16'h0000) begin errors++; $display("FAIL reset_mar: got %h expected 0000", bus.MAR_OUT); end
    checks++; if (bus.MDR_OUT !== 16'h0000) begin errors++; $display("FAIL reset_mdr: got %h expected 0000", bus.MDR_OUT); end
    tick();
  endtask

  task automatic test_store_load;
    int lat, en; logic [15:0] rd; logic err, pulse;
    run_access(1'b1, 16'h3000, 16'hBEEF, lat, en, rd, err, pulse);
    checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency: got %0d expected 4", lat); end
    checks++; if (en !== 2) begin errors++; $display("FAIL store_mem_en_cycles: got %0d expected 2", en); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", err); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL store_rdata: got %h expected 0000", rd); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL store_single_pulse: got %b expected 1", pulse); end
    run_access(1'b0, 16'h3000, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (lat !== 4) begin errors++; $display("FAIL load_latency: got %0d expected 4", lat); end
    checks++; if (en !== 2) begin errors++; $display("FAIL load_mem_en_cycles: got %0d expected 2", en); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", err); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL load_rdata: got %h expected beef", rd); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL load_single_pulse: got %b expected 1", pulse); end
  endtask

  task automatic test_out_of_range;
    int lat, en; logic [15:0] rd; logic err, pulse;
    run_access(1'b0, 16'h7080, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (lat !== 0) begin errors++; $display("FAIL oor_latency: got %0d expected 0", lat); end
    checks++; if (en !== 0) begin errors++; $display("FAIL oor_mem_en_cycles: got %0d expected 0", en); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL oor_rdata: got %h expected 0000", rd); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL oor_single_pulse: got %b expected 1", pulse); end
  endtask

  task automatic test_boundary;
    int lat, en; logic [15:0] rd; logic err, pulse;
    run_access(1'b1, 16'h707F, 16'h1234, lat, en, rd, err, pulse);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL boundary_store_err: got %b expected 0", err); end
    checks++; if (en !== 2) begin errors++; $display("FAIL boundary_store_mem_en: got %0d expected 2", en); end
    run_access(1'b0, 16'h707F, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL boundary_load_err: got %b expected 0", err); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL boundary_load_rdata: got %h expected 1234", rd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL boundary_load_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_dead_memory;
    int lat, en; logic [15:0] rd; logic err, pulse;
    mem_dead = 1'b1;
    run_access(1'b0, 16'h0010, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (lat !== 15) begin errors++; $display("FAIL dead_latency: got %0d expected 15", lat); end
    checks++; if (en !== 15) begin errors++; $display("FAIL dead_mem_en_cycles: got %0d expected 15", en); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL dead_err: got %b expected 1", err); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL dead_rdata: got %h expected 0000", rd); end
    mem_dead = 1'b0;
    run_access(1'b0, 16'h3000, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (lat !== 4) begin errors++; $display("FAIL after_dead_latency: got %0d expected 4", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL after_dead_err: got %b expected 0", err); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL after_dead_rdata: got %h expected beef", rd); end
  endtask

  task automatic test_reset_mid_op;
    int lat, en; logic [15:0] rd; logic err, pulse; logic seen_rsp;
    run_access(1'b1, 16'h0000, 16'h5A5A, lat, en, rd, err, pulse);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_store_err: got %b expected 0", err); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
    tick();
    req_valid = 1'b0;
    checks++; if (bus.MEM_EN !== 1'b1) begin errors++; $display("FAIL midrst_in_wait_ack: got MEM_EN %b expected 1", bus.MEM_EN); end
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    checks++; if (bus.MEM_EN !== 1'b0) begin errors++; $display("FAIL midrst_mem_en: got %b expected 0", bus.MEM_EN); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b expected 1", req_ready); end
    seen_rsp = rsp_valid;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    checks++; if (seen_rsp !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %b expected 0", seen_rsp); end
    run_access(1'b0, 16'h0000, 16'h0000, lat, en, rd, err, pulse);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_load_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL midrst_load_rdata: got %h expected 5a5a", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_load_err: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back;
    int guard, n_rsp, rsp1_t, rsp2_t, en_cyc, en_rises;
    logic en_prev, drop; logic [15:0] rd2;
    n_rsp = 0; rsp1_t = -1; rsp2_t = -1; en_cyc = 0; en_rises = 0; en_prev = 1'b0; rd2 = 16'hxxxx;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0200; req_wdata = 16'hAAAA;
    tick();
    // Second request is presented immediately and held until accepted.
    req_we = 1'b0; req_wdata = 16'h0000;
    for (int t = 0; t < 30; t++) begin
      if (rsp_valid) begin
        if (n_rsp == 0) rsp1_t = t;
        else begin rsp2_t = t; rd2 = rsp_rdata; end
        n_rsp++;
      end
      if (bus.MEM_EN && !en_prev) en_rises++;
      if (bus.MEM_EN) en_cyc++;
      en_prev = bus.MEM_EN;
      drop = req_valid && req_ready;
      tick();
      if (drop) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++; if (n_rsp !== 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 2", n_rsp); end
    checks++; if (rsp1_t !== 4) begin errors++; $display("FAIL b2b_first_rsp: got %0d expected 4", rsp1_t); end
    checks++; if (rsp2_t !== 10) begin errors++; $display("FAIL b2b_second_rsp: got %0d expected 10", rsp2_t); end
    checks++; if (en_rises !== 2) begin errors++; $display("FAIL b2b_mem_en_pulses: got %0d expected 2", en_rises); end
    checks++; if (en_cyc !== 4) begin errors++; $display("FAIL b2b_mem_en_cycles: got %0d expected 4", en_cyc); end
    checks++; if (rd2 !== 16'hAAAA) begin errors++; $display("FAIL b2b_second_rdata: got %h expected aaaa", rd2); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_boundary();
    test_dead_memory();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
